// File: rtl/clk_disp_pkg.sv
// Shared 7-segment display constants: segment patterns and bit positions within seg.
package clk_disp_pkg;

    localparam int unsigned SEG_W  = 7;  // width of the {g,f,e,d,c,b,a} field
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_DASH  = SEG_W'(1 << SEG_G);
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder; invalid codes 10..15 render as a dash.
module bcd_to_seg7
    import clk_disp_pkg::*;
(
    input  logic [3:0]       bcd_i,
    output logic [SEG_W-1:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed common-cathode scanner for HH:MM:SS BCD digits with per-frame snapshot,
// blink, leading-zero blanking and dead time between digits.
module bcd_display_scanner
    import clk_disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned DEAD       = 2,
    parameter int unsigned BLINK_DIV  = 64
) (
    input  logic                    in_clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_bcd,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    blank_lead,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   com,
    output logic                    frame_start
);

    localparam int unsigned PreW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned FcW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PreW-1:0] PreLast = PreW'(SCAN_DIV - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);
    localparam logic [FcW-1:0]  FcLast  = FcW'(BLINK_DIV - 1);

    logic [PreW-1:0]         pre_q, pre_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [FcW-1:0]          fc_q, fc_d;
    logic                    blink_on_q, blink_on_d;
    logic                    first_q, first_d;
    logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   com_q, com_d;

    logic             load;
    logic             dead;
    logic             blinked;
    logic             lead_zero;
    logic [3:0]       digit;
    logic [SEG_W-1:0] dec;

    assign load        = (pre_q == '0) && (idx_q == '0);
    assign frame_start = load && !rst;
    assign digit       = snap_q[4*idx_q +: 4];

    bcd_to_seg7 u_dec (
        .bcd_i (digit),
        .seg_o (dec)
    );

    always_comb begin
        pre_d      = (pre_q == PreLast) ? '0 : pre_q + 1'b1;
        idx_d      = idx_q;
        snap_d     = snap_q;
        fc_d       = fc_q;
        blink_on_d = blink_on_q;
        first_d    = first_q;

        if (pre_q == PreLast) begin
            idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
        end

        // The load right after reset restarts the blink phase instead of advancing it.
        if (load) begin
            snap_d  = digits_bcd;
            first_d = 1'b0;
            if (!first_q) begin
                if (fc_q == FcLast) begin
                    fc_d       = '0;
                    blink_on_d = !blink_on_q;
                end else begin
                    fc_d = fc_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        dead      = (32'(pre_q) < DEAD);
        blinked   = blink_mask[idx_q] && !blink_on_q;
        lead_zero = blank_lead && (idx_q == IdxLast) && (digit == 4'd0);
        seg_d     = '0;
        com_d     = '1;

        if (!dead) begin
            com_d              = ~(NUM_DIGITS'(1) << idx_q);
            seg_d[SEG_W-1:0]   = (blinked || lead_zero) ? SEG_BLANK : dec;
            seg_d[SEG_DP]      = dp_mask[idx_q] && !blinked;
        end
    end

    always_ff @(posedge in_clk) begin
        if (rst) begin
            pre_q      <= '0;
            idx_q      <= '0;
            fc_q       <= '0;
            blink_on_q <= 1'b1;
            first_q    <= 1'b1;
            snap_q     <= '0;
            seg_q      <= '0;
            com_q      <= '1;
        end else begin
            pre_q      <= pre_d;
            idx_q      <= idx_d;
            fc_q       <= fc_d;
            blink_on_q <= blink_on_d;
            first_q    <= first_d;
            snap_q     <= snap_d;
            seg_q      <= seg_d;
            com_q      <= com_d;
        end
    end

    assign seg = seg_q;
    assign com = com_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed self-checking bench for bcd_display_scanner with a 4-cycle slot and 1-cycle dead time.
module tb_bcd_display_scanner;

    logic        in_clk = 1'b0;
    logic        rst;
    logic [23:0] digits_bcd;
    logic [5:0]  blink_mask;
    logic [5:0]  dp_mask;
    logic        blank_lead;
    logic [7:0]  seg;
    logic [5:0]  com;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    always #5 in_clk = ~in_clk;

    bcd_display_scanner #(
        .NUM_DIGITS (6),
        .SCAN_DIV   (4),
        .DEAD       (1),
        .BLINK_DIV  (2)
    ) u_dut (
        .in_clk      (in_clk),
        .rst         (rst),
        .digits_bcd  (digits_bcd),
        .blink_mask  (blink_mask),
        .dp_mask     (dp_mask),
        .blank_lead  (blank_lead),
        .seg         (seg),
        .com         (com),
        .frame_start (frame_start)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample on the falling edge; never more than one common low.
    task automatic next_cycle();
        @(posedge in_clk);
        @(negedge in_clk);
        check("com_onehot", 32'($countones(~com) > 1), 32'd0);
    endtask

    // One full frame: per slot one dead cycle then three lit cycles. exp_seg holds slot k
    // at [8k+7:8k]. digits_bcd is replaced with chg_val during slot chg_slot.
    task automatic run_frame(input string tag, input logic [47:0] exp_seg,
                             input int chg_slot, input logic [23:0] chg_val);
        logic [5:0] exp_com;
        for (int s = 0; s < 6; s++) begin
            for (int p = 0; p < 4; p++) begin
                next_cycle();
                if (s == chg_slot && p == 1) digits_bcd = chg_val;
                if (p == 0) begin
                    check($sformatf("%s_s%0d_dead_com", tag, s), 32'(com), 32'h3F);
                    check($sformatf("%s_s%0d_dead_seg", tag, s), 32'(seg), 32'h00);
                end else begin
                    exp_com = ~(6'b000001 << s);
                    check($sformatf("%s_s%0d_com", tag, s), 32'(com), 32'(exp_com));
                    check($sformatf("%s_s%0d_seg", tag, s), 32'(seg), 32'(exp_seg[8*s +: 8]));
                end
                if (s == 3 && p == 2) begin
                    check($sformatf("%s_fs_mid", tag), 32'(frame_start), 32'd0);
                end
            end
        end
        check($sformatf("%s_fs_end", tag), 32'(frame_start), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        digits_bcd = 24'h235959;
        blink_mask = 6'b000000;
        dp_mask    = 6'b000000;
        blank_lead = 1'b0;

        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check("rst_com", 32'(com), 32'h3F);
            check("rst_seg", 32'(seg), 32'h00);
            check("rst_fs", 32'(frame_start), 32'd0);
        end
        rst = 1'b0;
        #1;
        check("fs_after_rst", 32'(frame_start), 32'd1);

        // 23:59:59 -> 9,5,9,5,3,2; digits change mid-frame in the second frame.
        run_frame("f1", 48'h5B4F_6D6F_6D6F, -1, 24'h0);
        run_frame("f2", 48'h5B4F_6D6F_6D6F, 2, 24'h000000);
        blank_lead = 1'b1;
        run_frame("f3", 48'h003F_3F3F_3F3F, -1, 24'h0);

        // Invalid BCD shows a dash; decimal point on digit 2 only.
        digits_bcd = 24'h00000C;
        blank_lead = 1'b0;
        dp_mask    = 6'b000100;
        run_frame("f4", 48'h3F3F_3FBF_3F40, -1, 24'h0);

        // Blink digits 5,4; dp on 5,4,0 (dp on blinked digits is cleared while off).
        digits_bcd = 24'h123456;
        blink_mask = 6'b110000;
        dp_mask    = 6'b110001;
        run_frame("f5_on", 48'h86DB_4F66_6DFD, -1, 24'h0);
        run_frame("f6_on", 48'h86DB_4F66_6DFD, -1, 24'h0);
        run_frame("f7_off", 48'h0000_4F66_6DFD, -1, 24'h0);
        run_frame("f8_off", 48'h0000_4F66_6DFD, -1, 24'h0);
        run_frame("f9_on", 48'h86DB_4F66_6DFD, -1, 24'h0);

        // Reset in the middle of slot 3's lit window.
        for (int i = 0; i < 15; i++) next_cycle();
        check("pre_rst_com", 32'(com), 32'h37);
        check("pre_rst_seg", 32'(seg), 32'h4F);
        rst = 1'b1;
        next_cycle();
        check("mid_rst_com", 32'(com), 32'h3F);
        check("mid_rst_seg", 32'(seg), 32'h00);
        check("mid_rst_fs", 32'(frame_start), 32'd0);
        rst = 1'b0;
        #1;
        check("fs_after_rst2", 32'(frame_start), 32'd1);
        run_frame("r1_on", 48'h86DB_4F66_6DFD, -1, 24'h0);
        run_frame("r2_on", 48'h86DB_4F66_6DFD, -1, 24'h0);
        run_frame("r3_off", 48'h0000_4F66_6DFD, -1, 24'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
